// File: rtl/layer_compositor.sv
// Priority compositor for indexed-color layers: per-layer palettes, a three-stage pixel
// pipeline, and a frame-stepped fade engine that scales the final RGB.
module layer_compositor #(
    parameter int                     NUM_LAYERS = 4,
    parameter int                     IDX_W      = 4,
    parameter int                     COLOR_W    = 8,
    parameter int                     FADE_LOG2  = 4,
    parameter logic [3*COLOR_W-1:0]   BG_COLOR   = 24'h000000
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          pix_valid_in,
    input  logic [NUM_LAYERS*IDX_W-1:0]   layer_idx,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic                          pal_we,
    input  logic [$clog2(NUM_LAYERS)-1:0] pal_layer,
    input  logic [IDX_W-1:0]              pal_addr,
    input  logic [3*COLOR_W-1:0]          pal_data,
    input  logic                          frame_start,
    input  logic                          fade_req,
    input  logic                          fade_dir,
    output logic                          fade_busy,
    output logic [FADE_LOG2:0]            fade_level,
    output logic                          pix_valid_out,
    output logic [COLOR_W-1:0]            VGA_R,
    output logic [COLOR_W-1:0]            VGA_G,
    output logic [COLOR_W-1:0]            VGA_B
);
    // state    | meaning
    // IDLE     | level held, fade_req accepted
    // FADE_OUT | level steps down on frame_start until 0
    // FADE_IN  | level steps up on frame_start until full scale
    typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} state_t;

    localparam int DEPTH = 2 ** IDX_W;
    localparam int CW3   = 3 * COLOR_W;
    localparam int PW    = COLOR_W + FADE_LOG2 + 1;
    localparam logic [FADE_LOG2:0] LVL_MAX = {1'b1, {FADE_LOG2{1'b0}}};

    logic [CW3-1:0]              pal_q [NUM_LAYERS][DEPTH];
    logic                        pal_wr_ok;
    logic [31:0]                 pal_layer_ext;

    logic                        s1_valid_q;
    logic [NUM_LAYERS*IDX_W-1:0] s1_idx_q;
    logic [NUM_LAYERS-1:0]       s1_en_q;
    logic [CW3-1:0]              win_color;
    logic                        s2_valid_q;
    logic [CW3-1:0]              s2_color_q;
    logic [CW3-1:0]              rgb_d, rgb_q;
    logic                        valid_q;

    state_t                      state_q, state_d;
    logic [FADE_LOG2:0]          level_q, level_d;

    assign pal_layer_ext = 32'(pal_layer);
    assign pal_wr_ok     = pal_we && (pal_layer_ext < 32'(NUM_LAYERS));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int l = 0; l < NUM_LAYERS; l++)
                for (int a = 0; a < DEPTH; a++)
                    pal_q[l][a] <= '0;
        end else if (pal_wr_ok) begin
            pal_q[pal_layer][pal_addr] <= pal_data;
        end
    end

    // Ascending scan: the last opaque layer found is the highest-priority one.
    always_comb begin
        win_color = BG_COLOR;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (s1_en_q[k] && (s1_idx_q[k*IDX_W +: IDX_W] != '0))
                win_color = pal_q[k][s1_idx_q[k*IDX_W +: IDX_W]];
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        logic [PW-1:0] prod;
        assign prod = PW'(s2_color_q[ch*COLOR_W +: COLOR_W]) * PW'(level_q);
        assign rgb_d[ch*COLOR_W +: COLOR_W] = s2_valid_q ? prod[FADE_LOG2 +: COLOR_W] : '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_en_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_color_q <= '0;
            valid_q    <= 1'b0;
            rgb_q      <= '0;
        end else begin
            s1_valid_q <= pix_valid_in;
            s1_idx_q   <= layer_idx;
            s1_en_q    <= layer_en;
            s2_valid_q <= s1_valid_q;
            s2_color_q <= win_color;
            valid_q    <= s2_valid_q;
            rgb_q      <= rgb_d;
        end
    end

    assign pix_valid_out = valid_q;
    assign VGA_R         = rgb_q[2*COLOR_W +: COLOR_W];
    assign VGA_G         = rgb_q[COLOR_W +: COLOR_W];
    assign VGA_B         = rgb_q[0 +: COLOR_W];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            level_q <= LVL_MAX;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            IDLE: begin
                if (fade_req)
                    state_d = fade_dir ? FADE_IN : FADE_OUT;
            end
            FADE_OUT: begin
                if (frame_start) begin
                    if (level_q != '0)
                        level_d = level_q - 1'b1;
                    if (level_d == '0)
                        state_d = IDLE;
                end
            end
            FADE_IN: begin
                if (frame_start) begin
                    if (level_q != LVL_MAX)
                        level_d = level_q + 1'b1;
                    if (level_d == LVL_MAX)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fade_busy  = (state_q != IDLE);
        fade_level = level_q;
    end
endmodule

// File: tb/tb_layer_compositor.sv
// Directed and randomized checks of layer_compositor against a spec-level reference model
// (palette array, priority search, integer scaling, fade rules applied once per clock).
module tb_layer_compositor;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        pix_valid_in;
    logic [15:0] layer_idx;
    logic [3:0]  layer_en;
    logic        pal_we;
    logic [1:0]  pal_layer;
    logic [3:0]  pal_addr;
    logic [23:0] pal_data;
    logic        frame_start;
    logic        fade_req;
    logic        fade_dir;
    logic        fade_busy;
    logic [4:0]  fade_level;
    logic        pix_valid_out;
    logic [7:0]  VGA_R, VGA_G, VGA_B;

    int checks = 0;
    int errors = 0;

    layer_compositor dut (
        .Clk(Clk), .Reset(Reset), .pix_valid_in(pix_valid_in),
        .layer_idx(layer_idx), .layer_en(layer_en),
        .pal_we(pal_we), .pal_layer(pal_layer), .pal_addr(pal_addr), .pal_data(pal_data),
        .frame_start(frame_start), .fade_req(fade_req), .fade_dir(fade_dir),
        .fade_busy(fade_busy), .fade_level(fade_level), .pix_valid_out(pix_valid_out),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    always #5 Clk = ~Clk;

    // Reference model state
    logic [23:0] m_pal [4][16];
    int          m_lvl;
    bit          m_busy, m_dir;
    bit          m1_v, m2_v, m3_v;
    logic [15:0] m1_idx;
    logic [3:0]  m1_en;
    logic [23:0] m2_c, m3_c;

    function automatic logic [23:0] resolve(input logic [15:0] idx, input logic [3:0] en);
        for (int k = 3; k >= 0; k--)
            if (en[k] && ((idx >> (4*k)) & 16'hF) != 0)
                return m_pal[k][(idx >> (4*k)) & 16'hF];
        return 24'h000000;
    endfunction

    function automatic logic [23:0] scale(input logic [23:0] c, input int lvl);
        int r, g, b;
        r = ((c >> 16) & 255) * lvl / 16;
        g = ((c >> 8) & 255) * lvl / 16;
        b = (c & 255) * lvl / 16;
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    function automatic void m_reset();
        for (int l = 0; l < 4; l++)
            for (int a = 0; a < 16; a++)
                m_pal[l][a] = 24'h0;
        m_lvl = 16; m_busy = 0; m_dir = 0;
        m1_v = 0; m2_v = 0; m3_v = 0;
        m1_idx = 0; m1_en = 0; m2_c = 0; m3_c = 0;
    endfunction

    // One clock edge of the specified behaviour, using the inputs held across that edge.
    function automatic void m_step();
        m3_v = m2_v;
        m3_c = m2_v ? scale(m2_c, m_lvl) : 24'h0;
        m2_v = m1_v;
        m2_c = resolve(m1_idx, m1_en);
        m1_v = pix_valid_in; m1_idx = layer_idx; m1_en = layer_en;
        if (pal_we) m_pal[pal_layer][pal_addr] = pal_data;
        if (!m_busy) begin
            if (fade_req) begin m_busy = 1; m_dir = fade_dir; end
        end else if (frame_start) begin
            if (!m_dir) begin
                if (m_lvl > 0) m_lvl--;
                if (m_lvl == 0) m_busy = 0;
            end else begin
                if (m_lvl < 16) m_lvl++;
                if (m_lvl == 16) m_busy = 0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_R"}, 32'(VGA_R), 32'(m3_c[23:16]));
        chk({tag, "_G"}, 32'(VGA_G), 32'(m3_c[15:8]));
        chk({tag, "_B"}, 32'(VGA_B), 32'(m3_c[7:0]));
        chk({tag, "_valid"}, 32'(pix_valid_out), 32'(m3_v));
        chk({tag, "_level"}, 32'(fade_level), 32'(m_lvl));
        chk({tag, "_busy"}, 32'(fade_busy), 32'(m_busy));
    endtask

    task automatic tick(input string tag);
        @(posedge Clk);
        m_step();
        #1;
        check_all(tag);
        pal_we = 0; fade_req = 0; frame_start = 0;
    endtask

    task automatic pal_write(input logic [1:0] l, input logic [3:0] a, input logic [23:0] d);
        pal_we = 1; pal_layer = l; pal_addr = a; pal_data = d;
    endtask

    task automatic pixel(input logic v, input logic [15:0] idx, input logic [3:0] en);
        pix_valid_in = v; layer_idx = idx; layer_en = en;
    endtask

    initial begin
        Reset = 1; pix_valid_in = 0; layer_idx = 0; layer_en = 0;
        pal_we = 0; pal_layer = 0; pal_addr = 0; pal_data = 0;
        frame_start = 0; fade_req = 0; fade_dir = 0;
        m_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_all("reset");
        Reset = 0;
        tick("idle");

        // Priority resolution and background
        pal_write(2'd0, 4'd1, 24'h102030); tick("wr0");
        pal_write(2'd3, 4'd2, 24'hFF8000); tick("wr3");
        pixel(1, 16'h2001, 4'hF); tick("pA");
        pixel(1, 16'h2001, 4'h7); tick("pB");
        pixel(1, 16'h0000, 4'hF); tick("pC");
        pixel(0, 16'h0000, 4'h0);
        chk("prio_l3", {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFF8000);
        tick("d1");
        chk("prio_l0", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h102030);
        tick("d2");
        chk("prio_bg", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h000000);
        chk("prio_bg_valid", 32'(pix_valid_out), 32'd1);
        tick("d3");

        // Write lands while the first pixel reads the same entry
        pixel(1, 16'h2000, 4'hF); tick("rwA");
        pixel(1, 16'h2000, 4'hF); pal_write(2'd3, 4'd2, 24'h123456); tick("rwB");
        pixel(0, 16'h0, 4'h0); tick("rw1");
        chk("rw_old", {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFF8000);
        tick("rw2");
        chk("rw_new", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h123456);
        pal_write(2'd3, 4'd2, 24'hFF8000); tick("rw3");

        // Fade out over 16 frames with a continuous pixel stream
        pixel(1, 16'h2001, 4'hF);
        fade_req = 1; fade_dir = 0; tick("fo_req");
        for (int i = 0; i < 16; i++) begin
            frame_start = 1; tick("fo_fs");
            chk("fo_level", 32'(fade_level), 32'(15 - i));
            chk("fo_busy", 32'(fade_busy), (i == 15) ? 32'd0 : 32'd1);
            if (i == 4) begin fade_req = 1; fade_dir = 1; end
            tick("fo_gap");
            if (i == 7) begin
                repeat (3) tick("fo_l8");
                chk("fade_l8", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h7F4000);
            end
        end

        // Request coincident with frame_start, then fade back in
        fade_req = 1; fade_dir = 1; frame_start = 1; tick("fi_req");
        chk("fi_nostep", 32'(fade_level), 32'd0);
        for (int i = 0; i < 16; i++) begin
            frame_start = 1; tick("fi_fs");
            tick("fi_gap");
        end
        chk("fi_top", 32'(fade_level), 32'd16);
        fade_req = 1; fade_dir = 1; tick("fi_max_req");
        chk("fi_max_busy", 32'(fade_busy), 32'd1);
        frame_start = 1; tick("fi_max_fs");
        chk("fi_max_idle", 32'(fade_busy), 32'd0);
        chk("fi_max_level", 32'(fade_level), 32'd16);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            pixel(1'($urandom_range(0, 3) != 0), 16'($urandom), 4'($urandom));
            if ($urandom_range(0, 3) == 0)
                pal_write(2'($urandom), 4'($urandom), 24'($urandom));
            frame_start = ($urandom_range(0, 7) == 0);
            fade_req    = ($urandom_range(0, 29) == 0);
            fade_dir    = 1'($urandom);
            tick("rnd");
        end

        // Reset in the middle of a pixel stream
        for (int p = 0; p < 5; p++) begin
            pixel(1, 16'($urandom), 4'hF); tick("rs_pre");
        end
        Reset = 1;
        #1;
        m_reset();
        check_all("rs_async");
        chk("rs_valid_low", 32'(pix_valid_out), 32'd0);
        @(posedge Clk); #1;
        check_all("rs_hold");
        Reset = 0;
        pixel(0, 16'h0, 4'h0); tick("rs_gap");
        for (int p = 0; p < 10; p++) begin
            pixel(1, 16'($urandom), 4'($urandom)); tick("rs_post");
            if (p == 1) chk("rs_not_yet", 32'(pix_valid_out), 32'd0);
            if (p == 2) chk("rs_resume", 32'(pix_valid_out), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
